// File: rtl/wb_ram_ctrl_if.sv
// Wishbone B3 signal bundle between an interconnect master and wb_ram_ctrl.
interface wb_ram_ctrl_if #(
  parameter int aw = 10
);
  logic [aw-1:0] wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    wb_bte_i;
  logic          wb_ack_o;
  logic [31:0]   wb_dat_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/wb_ram_ctrl.sv
// Wishbone B3 slave in front of a 32-bit single-port-style RAM with 1-cycle registered read.
// Supports classic and incrementing bursts; byte-lane writes are done by read-modify-write.
module wb_ram_ctrl #(
  parameter int depth = 256,
  parameter int aw    = $clog2(depth) + 2
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  wb_ram_ctrl_if.slave  wb,
  output logic          ram_we,
  output logic [aw-3:0] ram_waddr,
  output logic [31:0]   ram_din,
  output logic [aw-3:0] ram_raddr,
  input  logic [31:0]   ram_dout
);
  localparam int waw = aw - 2;

  typedef enum logic [2:0] {IDLE, RD, WR, RMW, BURST} state_t;

  state_t         state_reg;
  logic           ack_reg;
  logic           we_reg;
  logic           burst_reg;
  logic [waw-1:0] addr_reg;
  logic [waw-1:0] mask_reg;
  logic [31:0]    dat_reg;
  logic [3:0]     sel_reg;

  logic           bus_live;
  logic           req;
  logic           full_sel;
  logic           part_beat;
  logic           cti_incr;
  logic [waw-1:0] adr_word;
  logic [waw-1:0] next_addr;
  logic [waw-1:0] bte_mask;
  logic [31:0]    merged;
  logic           unused_adr_lsb;

  assign bus_live       = wb.wb_cyc_i & wb.wb_stb_i;
  assign req            = bus_live & ~wb.wb_ack_o;
  assign full_sel       = (wb.wb_sel_i == 4'hF);
  assign cti_incr       = (wb.wb_cti_i == 3'b010);
  assign adr_word       = wb.wb_adr_i[aw-1:2];
  assign unused_adr_lsb = ^wb.wb_adr_i[1:0];

  // A partial-sel beat inside a write burst must not be acked until its merge is written.
  assign part_beat   = (state_reg == BURST) & we_reg & ~full_sel;
  assign wb.wb_ack_o = ack_reg & bus_live & ~part_beat;
  assign wb.wb_dat_o = ram_dout;

  always_comb begin
    bte_mask = '1;
    case (wb.wb_bte_i)
      2'b01:   begin bte_mask = '0; bte_mask[3:0] = 4'h3; end
      2'b10:   begin bte_mask = '0; bte_mask[3:0] = 4'h7; end
      2'b11:   begin bte_mask = '0; bte_mask[3:0] = 4'hF; end
      default: bte_mask = '1;
    endcase
  end

  // Wrapping bursts only advance the masked low bits; linear bursts roll over at depth.
  assign next_addr = (addr_reg & ~mask_reg) | ((addr_reg + 1'b1) & mask_reg);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged[8*gi +: 8] = sel_reg[gi] ? dat_reg[8*gi +: 8] : ram_dout[8*gi +: 8];
  end

  // Write bursts look at the beat in flight so a partial beat can start its merge read at once.
  always_comb begin
    ram_raddr = addr_reg;
    if (state_reg == IDLE)
      ram_raddr = adr_word;
    else if (state_reg == BURST && !we_reg)
      ram_raddr = next_addr;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
      we_reg    <= 1'b0;
      burst_reg <= 1'b0;
      addr_reg  <= '0;
      mask_reg  <= '1;
      dat_reg   <= '0;
      sel_reg   <= '0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_din   <= '0;
    end else begin
      ram_we <= 1'b0;
      case (state_reg)
        IDLE: begin
          ack_reg <= 1'b0;
          // Hold off one cycle while the last burst beat is still being written.
          if (req && !ram_we) begin
            addr_reg  <= adr_word;
            mask_reg  <= bte_mask;
            we_reg    <= wb.wb_we_i;
            burst_reg <= cti_incr;
            dat_reg   <= wb.wb_dat_i;
            sel_reg   <= wb.wb_sel_i;
            if (!wb.wb_we_i) begin
              ack_reg   <= 1'b1;
              state_reg <= cti_incr ? BURST : RD;
            end else if (!full_sel) begin
              state_reg <= RMW;
            end else if (cti_incr) begin
              ack_reg   <= 1'b1;
              state_reg <= BURST;
            end else begin
              ram_we    <= 1'b1;
              ram_waddr <= adr_word;
              ram_din   <= wb.wb_dat_i;
              ack_reg   <= 1'b1;
              state_reg <= WR;
            end
          end
        end
        RD: begin
          ack_reg   <= 1'b0;
          state_reg <= IDLE;
        end
        RMW: begin
          if (bus_live) begin
            ram_we    <= 1'b1;
            ram_waddr <= addr_reg;
            ram_din   <= merged;
            ack_reg   <= 1'b1;
            state_reg <= WR;
          end else begin
            ack_reg   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        WR: begin
          if (burst_reg && bus_live && cti_incr) begin
            addr_reg  <= next_addr;
            ack_reg   <= 1'b1;
            state_reg <= BURST;
          end else begin
            ack_reg   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        BURST: begin
          if (!bus_live) begin
            ack_reg   <= 1'b0;
            state_reg <= IDLE;
          end else if (we_reg && !full_sel) begin
            dat_reg   <= wb.wb_dat_i;
            sel_reg   <= wb.wb_sel_i;
            ack_reg   <= 1'b0;
            state_reg <= RMW;
          end else begin
            if (we_reg) begin
              ram_we    <= 1'b1;
              ram_waddr <= addr_reg;
              ram_din   <= wb.wb_dat_i;
            end
            if (cti_incr) begin
              addr_reg <= next_addr;
            end else begin
              ack_reg   <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          ack_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_ram_ctrl.sv
// Self-checking bench for wb_ram_ctrl: RAM primitive model, Wishbone master tasks,
// and a word-array reference memory updated per acked beat.
module tb_wb_ram_ctrl;
  localparam int depth = 256;
  localparam int aw    = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_ram_ctrl_if #(.aw(aw)) wb ();

  logic          ram_we;
  logic [aw-3:0] ram_waddr;
  logic [31:0]   ram_din;
  logic [aw-3:0] ram_raddr;
  logic [31:0]   ram_dout;

  wb_ram_ctrl #(.depth(depth), .aw(aw)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb         (wb),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_din    (ram_din),
    .ram_raddr  (ram_raddr),
    .ram_dout   (ram_dout)
  );

  // RAM primitive: write without byte enables, registered read.
  logic [31:0] ram_mem [depth];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_waddr] <= ram_din;
    ram_dout <= ram_mem[ram_raddr];
  end

  int            we_pulses = 0;
  logic [aw-3:0] last_waddr;
  always @(posedge clk) begin
    if (ram_we) begin
      we_pulses  <= we_pulses + 1;
      last_waddr <= ram_waddr;
    end
  end

  logic [31:0] ref_mem  [depth];
  logic [31:0] beat_dat [depth];
  logic [3:0]  beat_sel [depth];
  logic [31:0] beat_rd  [depth];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic int beat_addr(input int start, input int i, input logic [1:0] bte,
                                   input bit burst);
    int len;
    if (!burst) return start;
    case (bte)
      2'b01:   len = 4;
      2'b10:   len = 8;
      2'b11:   len = 16;
      default: len = depth;
    endcase
    return (start / len) * len + (start % len + i) % len;
  endfunction

  task automatic drive_idle();
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_sel_i = 4'h0;
    wb.wb_adr_i = '0;
    wb.wb_dat_i = '0;
    wb.wb_cti_i = 3'b000;
    wb.wb_bte_i = 2'b00;
  endtask

  // One Wishbone cycle of `count` beats (classic when burst=0); stops early after
  // abort_after acks when that is nonzero. Beat data/sel come from beat_dat/beat_sel.
  task automatic run_txn(input string name, input bit we, input int start, input int count,
                         input logic [1:0] bte, input bit burst, input int abort_after);
    int   pulses0, len, acked, a, n, exp_lat;
    logic [3:0] s;
    pulses0 = we_pulses;
    len     = (abort_after > 0) ? abort_after : count;
    acked   = 0;
    for (int i = 0; i < len; i++) begin
      a = beat_addr(start, i, bte, burst);
      s = we ? beat_sel[i] : 4'hF;
      @(posedge clk); #1;
      wb.wb_cyc_i = 1'b1;
      wb.wb_stb_i = 1'b1;
      wb.wb_we_i  = we;
      wb.wb_adr_i = aw'(a * 4);
      wb.wb_dat_i = beat_dat[i];
      wb.wb_sel_i = s;
      wb.wb_cti_i = !burst ? 3'b000 : ((i == count - 1) ? 3'b111 : 3'b010);
      wb.wb_bte_i = bte;
      n = 0;
      @(negedge clk);
      while (!wb.wb_ack_o && n < 8) begin
        @(negedge clk);
        n++;
      end
      exp_lat = (we && s != 4'hF) ? 2 : ((i == 0) ? 1 : 0);
      check($sformatf("%s_lat%0d", name, i), 32'(n), 32'(exp_lat));
      if (!wb.wb_ack_o) begin
        drive_idle();
        return;
      end
      acked++;
      if (we) begin
        ref_mem[a] = merge(ref_mem[a], beat_dat[i], s);
      end else begin
        beat_rd[i] = wb.wb_dat_o;
        check($sformatf("%s_rd%0d", name, i), wb.wb_dat_o, ref_mem[a]);
      end
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check($sformatf("%s_ack_after", name), 32'(wb.wb_ack_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s_we_pulses", name), 32'(we_pulses - pulses0), we ? 32'(acked) : 32'd0);
    $display("txn %s we=%0d start=%0d beats=%0d acked=%0d burst=%0d bte=%0d",
             name, we, start, count, acked, burst, bte);
  endtask

  task automatic classic_write(input string name, input int word, input logic [31:0] d,
                               input logic [3:0] s);
    beat_dat[0] = d;
    beat_sel[0] = s;
    run_txn(name, 1'b1, word, 1, 2'b00, 1'b0, 0);
  endtask

  task automatic classic_read(input string name, input int word);
    run_txn(name, 1'b0, word, 1, 2'b00, 1'b0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, guard, cnt, st, ab;
    bit wr, bst;
    logic [1:0] bt;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(wb.wb_ack_o), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_waddr", 32'(ram_waddr), 32'd0);
    check("rst_din", ram_din, 32'd0);
    rst_n = 1'b1;

    // Fill the whole RAM through one long linear write burst.
    for (int i = 0; i < depth; i++) begin
      beat_dat[i] = $urandom;
      beat_sel[i] = 4'hF;
    end
    run_txn("fill", 1'b1, 0, depth, 2'b00, 1'b1, 0);

    classic_write("wr_04", 1, 32'hDEADBEEF, 4'hF);
    check("wr_04_waddr", 32'(last_waddr), 32'd1);
    classic_read("rd_04", 1);
    check("rd_04_data", beat_rd[0], 32'hDEADBEEF);

    classic_write("wr_08_full", 2, 32'h11223344, 4'hF);
    classic_write("wr_08_part", 2, 32'hAABBCCDD, 4'b0101);
    classic_read("rd_08", 2);
    check("rd_08_data", beat_rd[0], 32'h11BB33DD);

    classic_write("wr_sel0", 5, 32'hFFFFFFFF, 4'h0);
    classic_read("rd_sel0", 5);

    run_txn("rdb_lin", 1'b0, 254, 4, 2'b00, 1'b1, 0);

    for (int i = 0; i < 4; i++) begin
      beat_dat[i] = 32'(i + 1);
      beat_sel[i] = 4'hF;
    end
    run_txn("wrb_wrap4", 1'b1, 3, 4, 2'b01, 1'b1, 0);
    classic_read("rd_w3", 3); check("wrap4_w3", beat_rd[0], 32'd1);
    classic_read("rd_w0", 0); check("wrap4_w0", beat_rd[0], 32'd2);
    classic_read("rd_w1", 1); check("wrap4_w1", beat_rd[0], 32'd3);
    classic_read("rd_w2", 2); check("wrap4_w2", beat_rd[0], 32'd4);

    run_txn("rdb_abort", 1'b0, 20, 6, 2'b00, 1'b1, 2);
    classic_read("rd_after_abort", 20);

    for (int i = 0; i < 6; i++) begin
      beat_dat[i] = $urandom;
      beat_sel[i] = 4'hF;
    end
    run_txn("wrb_abort", 1'b1, 40, 6, 2'b10, 1'b1, 2);
    classic_read("rd_unacked_beat", 42);

    // Reset in the middle of a read burst.
    @(posedge clk); #1;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0; wb.wb_sel_i = 4'hF;
    wb.wb_adr_i = aw'(32'h10); wb.wb_cti_i = 3'b010; wb.wb_bte_i = 2'b00;
    acks = 0;
    guard = 0;
    while (acks < 2 && guard < 10) begin
      @(negedge clk);
      if (wb.wb_ack_o) acks++;
      guard++;
    end
    check("rst_burst_acks", 32'(acks), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ack", 32'(wb.wb_ack_o), 32'd0);
    check("midrst_ram_we", 32'(ram_we), 32'd0);
    check("midrst_waddr", 32'(ram_waddr), 32'd0);
    check("midrst_din", ram_din, 32'd0);
    drive_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    classic_read("rd_10_after_rst", 4);

    // Randomised mix of classic and burst cycles against the reference memory.
    for (int t = 0; t < 40; t++) begin
      wr  = 1'($urandom_range(0, 1));
      bst = 1'($urandom_range(0, 1));
      bt  = 2'($urandom_range(0, 3));
      cnt = bst ? $urandom_range(1, 8) : 1;
      st  = $urandom_range(0, depth - 1);
      ab  = (cnt > 1 && $urandom_range(0, 7) == 0) ? $urandom_range(1, cnt - 1) : 0;
      for (int i = 0; i < cnt; i++) begin
        beat_dat[i] = $urandom;
        beat_sel[i] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      end
      run_txn($sformatf("rnd%0d", t), wr, st, cnt, bt, bst, ab);
    end

    for (int w = 0; w < 8; w++) classic_read($sformatf("final%0d", w), w * 32 + 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/wb_ram_ctrl.md
Name: wb_ram_ctrl

Overview:
Wishbone B3 slave front-end that drives the team's generic single-clock 32-bit on-chip RAM (1-cycle registered read, write port without byte enables).
- Decodes classic and incrementing-burst Wishbone cycles into RAM read/write port activity.
- Emulates byte-lane writes with read-modify-write.
- Sits between the interconnect and the RAM primitive.

Parameters:
depth, 256, RAM size in 32-bit words; power of two, ≥16.
aw, $clog2(depth)+2, Wishbone byte-address width.

Ports:
wb_clk_i  input  1  clock for bus and RAM.
wb_rst_n_i  input  1  asynchronous active-low reset.
wb_adr_i  input  aw  byte address; bits [1:0] ignored.
wb_dat_i  input  32  write data.
wb_sel_i  input  4  byte lane selects.
wb_we_i  input  1  write enable.
wb_cyc_i  input  1  cycle valid.
wb_stb_i  input  1  strobe.
wb_cti_i  input  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
wb_bte_i  input  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
wb_ack_o  output  1  acknowledge.
wb_dat_o  output  32  read data; equals ram_dout.
ram_we  output  1  RAM write enable (registered).
ram_waddr  output  aw-2  RAM write word address (registered).
ram_din  output  32  RAM write data (registered).
ram_raddr  output  aw-2  RAM read word address (combinational).
ram_dout  input  32  RAM read data, valid one cycle after ram_raddr.

Behaviour:
- Reset (async, wb_rst_n_i=0):
  - state=IDLE; wb_ack_o=0, ram_we=0, ram_waddr=0, ram_din=0.
  - Burst address register cleared.
  - Reset mid-operation aborts the transfer; no write is issued after reset assertion.
- Request: req = wb_cyc_i & wb_stb_i & ~wb_ack_o.
- FSM states: IDLE, RD, WR, RMW, BURST.
- ram_raddr:
  - IDLE: wb_adr_i[aw-1:2].
  - BURST: next burst address.
  - otherwise: the held address.
- Classic read: accepted in cycle N, state goes to RD. Cycle N+1: wb_ack_o=1, wb_dat_o=ram_dout. Cycle N+2: ack=0, back to IDLE.
- Full write (sel=1111): accepted in cycle N; ram_we=1, ram_waddr and ram_din loaded at the N→N+1 edge. Cycle N+1: ram_we=1, wb_ack_o=1. Then IDLE.
- Partial write (sel≠1111, including 0000):
  - Cycle N: accept and read the word.
  - Cycle N+1 (RMW): merge lane-wise (sel bit=1 takes wb_dat_i, else ram_dout) into ram_din; assert ram_we.
  - Cycle N+2: write completes, ack=1.
  - sel=0000 rewrites the old word unchanged.
- Burst (cti=010 at acceptance):
  - Next word address = (A & ~m) | ((A+1) & m), where m=3/7/15 for wrap4/8/16.
  - Linear bursts wrap modulo depth.
  - Read burst: after the first ack at N+1, ack stays high every cycle while cyc&stb and cti=010. ram_raddr is pre-driven with the next address each cycle, so one word is returned per cycle. The beat with cti=111 is acked and then ack drops.
  - Full-sel write burst: one beat per cycle, ack continuous, each acked beat written to the successive address.
  - Partial-sel beat inside a burst: ack drops for that beat, which costs 2 cycles (RMW); the burst then resumes.
- Master drops cyc or stb mid-burst: return to IDLE the next cycle. The speculative read is discarded and no unacked beat is written.
- cti=111 or 000 on the first beat is handled as classic.
- wb_we_i, wb_sel_i and wb_adr_i are sampled only on acked/accepted beats.
- Never two acks for one classic request.

Test Plan:
- Reset asserted mid read-burst → ack=0 and ram_we=0 immediately; the subsequent classic read of 0x10 returns the stored value.
- Classic write 0x04=0xDEADBEEF sel=1111, then classic read 0x04 → ram_we high 1 cycle with waddr=1; read acks 1 cycle after stb with 0xDEADBEEF.
- Word 2=0x11223344, write 0x08 data 0xAABBCCDD sel=0101 → ack at N+2; read returns 0x11BB33DD.
- Linear read burst of 4 from 0x3F8 (depth=256) → data from words 254, 255, 0, 1 on 4 consecutive ack cycles; ack drops after the cti=111 beat.
- Wrap4 write burst from 0x0C, data 1..4, sel=1111 → words 3, 0, 1, 2 receive 1, 2, 3, 4; 4 consecutive acks.
- Read burst with cyc dropped after 2 acks → ack=0 next cycle, state IDLE, no ram_we pulses.
